// File: rtl/relu_maxpool_stream.sv
// relu_maxpool_stream
//   Streaming ReLU followed by a 2x2 / stride-2 max-pool over a raster-order
//   pixel stream. Only one row of horizontal pair-maxima is buffered.
//   Trailing odd row/column of the input frame is counted but ignored.
//
// Parameters
//   IMG_W, IMG_H    input frame width / height in pixels (>= 2)
// Ports
//   clk_i           clock, rising edge
//   rst_ni          asynchronous active-low reset
//   pixel_i         signed 8-bit input pixel
//   pix_data_valid  pixel_i valid this cycle (no backpressure)
//   conv_finished   end-of-frame pulse from upstream; resynchronises counters
//   pixel_o         pooled, rectified pixel (0..127), held between pulses
//   pix_valid_o     one-cycle pulse per pooled pixel
//   pool_finished_o one-cycle pulse with the last pooled pixel of a frame
module relu_maxpool_stream #(
    parameter int IMG_W = 26,
    parameter int IMG_H = 26
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] pixel_i,
    input  logic       pix_data_valid,
    input  logic       conv_finished,
    output logic [7:0] pixel_o,
    output logic       pix_valid_o,
    output logic       pool_finished_o
);

    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int BUF_N = IMG_W / 2;
    localparam int BW    = (BUF_N > 1) ? $clog2(BUF_N) : 1;

    localparam logic [CW-1:0] COL_LAST      = CW'(IMG_W - 1);
    localparam logic [CW-1:0] COL_POOL_LAST = CW'(2 * (IMG_W / 2) - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] ROW_POOL_LAST = RW'(2 * (IMG_H / 2) - 1);
    localparam bit            H_ODD         = (IMG_H % 2) == 1;

    typedef enum logic [1:0] {
        ROW_EVEN,
        ROW_ODD,
        DROP
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    hold;
    logic [7:0]    line_buf [BUF_N];

    logic [7:0]    relu;
    logic [7:0]    pair_max;
    logic [7:0]    buf_rd;
    logic [7:0]    win_max;
    logic [BW-1:0] buf_idx;
    logic          col_odd;
    logic          col_last;
    logic          row_last;
    logic          row_pool_last;
    logic          buf_wr;

    always_comb begin
        relu          = pixel_i[7] ? '0 : pixel_i;
        pair_max      = (hold > relu) ? hold : relu;
        // Truncating cast: the only out-of-range index is the ignored
        // trailing column of an odd-width frame, whose read is unused.
        buf_idx       = BW'(col >> 1);
        buf_rd        = line_buf[buf_idx];
        win_max       = (buf_rd > pair_max) ? buf_rd : pair_max;
        col_odd       = col[0];
        col_last      = (col == COL_LAST);
        row_last      = (row == ROW_LAST);
        row_pool_last = (row == ROW_POOL_LAST);
        buf_wr        = pix_data_valid && (state == ROW_EVEN) && col_odd;
    end

    // Line buffer has no reset: every entry is written on an even row
    // before the following odd row reads it.
    always_ff @(posedge clk_i) begin
        if (buf_wr) begin
            line_buf[buf_idx] <= pair_max;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state           <= ROW_EVEN;
            col             <= '0;
            row             <= '0;
            hold            <= '0;
            pixel_o         <= '0;
            pix_valid_o     <= 1'b0;
            pool_finished_o <= 1'b0;
        end else begin
            pix_valid_o     <= 1'b0;
            pool_finished_o <= 1'b0;

            if (pix_data_valid) begin
                if (!col_odd) begin
                    hold <= relu;
                end

                if (state == ROW_ODD && col_odd) begin
                    pixel_o         <= win_max;
                    pix_valid_o     <= 1'b1;
                    pool_finished_o <= row_pool_last && (col == COL_POOL_LAST);
                end

                if (col_last) begin
                    col <= '0;
                    row <= row_last ? '0 : row + RW'(1);
                    case (state)
                        ROW_EVEN: state <= ROW_ODD;
                        ROW_ODD:  state <= (row_pool_last && H_ODD) ? DROP : ROW_EVEN;
                        default:  state <= ROW_EVEN;
                    endcase
                end else begin
                    col <= col + CW'(1);
                end
            end

            // Resync takes priority over the counter advance above, but the
            // same-cycle pixel has already produced its output.
            if (conv_finished) begin
                col   <= '0;
                row   <= '0;
                state <= ROW_EVEN;
            end
        end
    end

endmodule

// File: tb/tb_relu_maxpool_stream.sv
// tb_relu_maxpool_stream
//   Three instances (4x4, 5x5, 26x26) share clock, reset, pixel bus and the
//   end-of-frame pulse; each has its own valid so only one advances at a time.
module tb_relu_maxpool_stream;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] pix;
    logic [2:0] vld;
    logic       conv;
    logic [7:0] po [3];
    logic       pv [3];
    logic       pf [3];

    always #5 clk = ~clk;

    relu_maxpool_stream #(.IMG_W(4), .IMG_H(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix), .pix_data_valid(vld[0]),
        .conv_finished(conv), .pixel_o(po[0]), .pix_valid_o(pv[0]),
        .pool_finished_o(pf[0])
    );

    relu_maxpool_stream #(.IMG_W(5), .IMG_H(5)) dut5 (
        .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix), .pix_data_valid(vld[1]),
        .conv_finished(conv), .pixel_o(po[1]), .pix_valid_o(pv[1]),
        .pool_finished_o(pf[1])
    );

    relu_maxpool_stream #(.IMG_W(26), .IMG_H(26)) dut26 (
        .clk_i(clk), .rst_ni(rst_n), .pixel_i(pix), .pix_data_valid(vld[2]),
        .conv_finished(conv), .pixel_o(po[2]), .pix_valid_o(pv[2]),
        .pool_finished_o(pf[2])
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int out_cnt  [3];
    int done_cnt [3];

    typedef struct {
        int         sel;
        logic [7:0] val;
        logic       done;
        int         cyc;
    } exp_t;

    exp_t sb [$];

    typedef struct {
        logic [7:0] pix;
        logic       conv;
        logic       ev;
        logic [7:0] ep;
        logic       ed;
    } vec_t;

    vec_t tbl [$];

    logic [7:0] fr [26][26];

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every output pulse must match the oldest
    // expectation in value, done flag, instance and cycle.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (pv[i]) begin
                out_cnt[i]++;
                if (pf[i]) done_cnt[i]++;
                tests++;
                if (sb.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out dut%0d: got pixel=%0d done=%0b, required no output",
                             i, po[i], pf[i]);
                end else begin
                    e = sb.pop_front();
                    if (e.sel != i || e.val !== po[i] || e.done !== pf[i] || e.cyc != cyc) begin
                        fails++;
                        $display("FAIL pooled_out dut%0d: got pixel=%0d done=%0b cyc=%0d, required dut%0d pixel=%0d done=%0b cyc=%0d",
                                 i, po[i], pf[i], cyc, e.sel, e.val, e.done, e.cyc);
                    end
                end
            end else if (pf[i]) begin
                tests++;
                fails++;
                $display("FAIL done_without_valid dut%0d: got done=1 valid=0, required done=0", i);
            end
        end
    end

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d", name, got, exp);
        end
    endtask

    task automatic send(input int sel, input logic [7:0] p, input logic c,
                        input logic ev, input logic [7:0] evl, input logic ed);
        @(negedge clk);
        pix  = p;
        vld  = 3'(1 << sel);
        conv = c;
        if (ev) sb.push_back('{sel, evl, ed, cyc + 1});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            vld  = '0;
            conv = 1'b0;
            pix  = 8'($urandom);
        end
    endtask

    task automatic drain(input string name);
        int budget;
        budget = 20;
        while (sb.size() != 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        check_int(name, sb.size(), 0);
    endtask

    function automatic logic [7:0] relu_m(input logic [7:0] x);
        return x[7] ? 8'd0 : x;
    endfunction

    function automatic logic [7:0] max_m(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? a : b;
    endfunction

    // Golden model: pools directly from the stored full frame.
    task automatic send_model(input int sel, input int w, input int h,
                              input int r, input int c, input logic [7:0] p);
        logic       ev;
        logic       ed;
        logic [7:0] evl;
        fr[r][c] = p;
        ev  = (r % 2 == 1) && (c % 2 == 1) && (r < 2 * (h / 2)) && (c < 2 * (w / 2));
        ed  = ev && (r == 2 * (h / 2) - 1) && (c == 2 * (w / 2) - 1);
        evl = 8'd0;
        if (ev) begin
            evl = max_m(max_m(relu_m(fr[r-1][c-1]), relu_m(fr[r-1][c])),
                        max_m(relu_m(fr[r][c-1]),   relu_m(fr[r][c])));
        end
        send(sel, p, 1'b0, ev, evl, ed);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int base_out;
        int base_done;

        rst_n = 1'b0;
        pix   = '0;
        vld   = '0;
        conv  = 1'b0;

        // 4x4 stimulus table: ramp, negated ramp (with -128), partial frame
        // cut by conv_finished after pixel 6, then a full ramp again.
        for (int i = 0; i < 16; i++)
            tbl.push_back('{8'(i), 1'b0, (i == 5 || i == 7 || i == 13 || i == 15), 8'(i), (i == 15)});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{(i == 0) ? 8'h80 : 8'(-i), 1'b0,
                            (i == 5 || i == 7 || i == 13 || i == 15), 8'd0, (i == 15)});
        for (int i = 0; i < 7; i++)
            tbl.push_back('{8'(i), (i == 6), (i == 5), 8'd5, 1'b0});
        for (int i = 0; i < 16; i++)
            tbl.push_back('{8'(i), 1'b0, (i == 5 || i == 7 || i == 13 || i == 15), 8'(i), (i == 15)});

        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check8("reset_pixel", po[i], 8'd0);
            check8("reset_valid", {7'd0, pv[i]}, 8'd0);
            check8("reset_done",  {7'd0, pf[i]}, 8'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k])
            send(0, tbl[k].pix, tbl[k].conv, tbl[k].ev, tbl[k].ep, tbl[k].ed);
        idle(3);
        drain("drain_4x4_table");
        check8("pixel_hold", po[0], 8'd15);
        check_int("done_count_4x4", done_cnt[0], 3);

        // Asynchronous reset after pixel 9 of a 4x4 frame.
        for (int i = 0; i < 10; i++)
            send(0, 8'(i), 1'b0, (i == 5 || i == 7), 8'(i), 1'b0);
        idle(2);
        drain("drain_pre_reset");
        check8("pre_reset_pixel", po[0], 8'd7);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check8("async_reset_pixel", po[0], 8'd0);
        check8("async_reset_valid", {7'd0, pv[0]}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            send_model(0, 4, 4, i / 4, i % 4, 8'(i));
        idle(3);
        drain("drain_post_reset");
        check8("post_reset_last", po[0], 8'd15);

        // 5x5: trailing row and column ignored.
        for (int i = 0; i < 25; i++)
            send_model(1, 5, 5, i / 5, i % 5, 8'(i));
        idle(3);
        drain("drain_5x5");
        check_int("out_count_5x5", out_cnt[1], 4);
        check_int("done_count_5x5", done_cnt[1], 1);
        check8("last_5x5", po[1], 8'd18);

        // 26x26 random data with random valid gaps.
        base_out  = out_cnt[2];
        base_done = done_cnt[2];
        for (int r = 0; r < 26; r++) begin
            for (int c = 0; c < 26; c++) begin
                if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
                send_model(2, 26, 26, r, c, 8'($urandom));
            end
        end
        idle(3);
        drain("drain_26x26");
        check_int("out_count_26x26", out_cnt[2] - base_out, 169);
        check_int("done_count_26x26", done_cnt[2] - base_done, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
